// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage controller that runs loads/stores over a req/ack bus, stalls while waiting,
// resolves branch/jump PC selection and registers results toward MEM/WB.
module mem_stage_ctrl #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memwrin,
  input  logic              memrdin,
  input  logic              bbnein,
  input  logic              bbeqin,
  input  logic              bblezin,
  input  logic              bbgtzin,
  input  logic              jumpin,
  input  logic              zeroin,
  input  logic              negativein,
  input  logic [DWIDTH-1:0] aluoutin,
  input  logic [DWIDTH-1:0] regdata2in,
  input  logic [4:0]        regdstmuxin,
  input  logic              regwrin,
  input  logic [1:0]        memtoregin,
  input  logic [AWIDTH-1:0] branaddrin,
  input  logic [AWIDTH-1:0] jmpaddrin,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              stall,
  output logic [1:0]        pcsrc,
  output logic [AWIDTH-1:0] pcaddr,
  output logic [DWIDTH-1:0] rdataout,
  output logic [DWIDTH-1:0] aluoutout,
  output logic [4:0]        regdstout,
  output logic              regwrout,
  output logic [1:0]        memtoregout,
  output logic              buserr
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic          access, aligned, issue, misal, tout, taken;

  assign access  = memrdin | memwrin;
  assign aligned = aluoutin[1:0] == 2'b00;
  assign issue   = state == IDLE && access && aligned;
  assign misal   = state == IDLE && access && !aligned;
  assign tout    = state == WAIT && !mem_ack && cnt == CW'(TIMEOUT);
  assign stall   = issue | (state == WAIT && !mem_ack && !tout);
  assign taken   = (bbeqin & zeroin) | (bbnein & !zeroin) | (bblezin & (zeroin | negativein))
                 | (bbgtzin & !zeroin & !negativein);
  assign pcsrc   = stall ? 2'b00 : jumpin ? 2'b10 : taken ? 2'b01 : 2'b00;
  assign pcaddr  = pcsrc == 2'b10 ? jmpaddrin : pcsrc == 2'b01 ? branaddrin : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rdataout    <= '0;
      aluoutout   <= '0;
      regdstout   <= '0;
      regwrout    <= 1'b0;
      memtoregout <= '0;
      buserr      <= 1'b0;
    end else begin
      buserr <= misal | tout;
      if (issue) begin
        state     <= WAIT;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= memwrin;
        mem_addr  <= aluoutin[AWIDTH-1:0];
        mem_wdata <= regdata2in;
      end else if (state == WAIT) begin
        if (mem_ack || tout) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end else cnt <= cnt + 1'b1;
      end
      // WB register advances whenever the pipeline is not frozen
      if (!stall) begin
        aluoutout   <= aluoutin;
        regdstout   <= regdstmuxin;
        memtoregout <= memtoregin;
        regwrout    <= regwrin & !misal & !tout;
        if (state == WAIT && mem_ack && !memwrin) rdataout <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized transaction-level check of mem_stage_ctrl against a per-instruction reference model.
module tb_mem_stage_ctrl;
  localparam int TIMEOUT = 15;
  logic        clk = 0, rst_n = 0;
  logic        memwrin, memrdin, bbnein, bbeqin, bblezin, bbgtzin, jumpin, zeroin, negativein;
  logic [31:0] aluoutin, regdata2in, branaddrin, jmpaddrin, mem_addr, mem_wdata, mem_rdata, pcaddr;
  logic [31:0] rdataout, aluoutout;
  logic [4:0]  regdstmuxin, regdstout;
  logic        regwrin, mem_req, mem_we, mem_ack, stall, regwrout, buserr;
  logic [1:0]  memtoregin, pcsrc, memtoregout;
  int          checks = 0, errors = 0;
  logic [31:0] exp_rdata = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .memwrin(memwrin), .memrdin(memrdin), .bbnein(bbnein), .bbeqin(bbeqin),
    .bblezin(bblezin), .bbgtzin(bbgtzin), .jumpin(jumpin), .zeroin(zeroin), .negativein(negativein),
    .aluoutin(aluoutin), .regdata2in(regdata2in), .regdstmuxin(regdstmuxin), .regwrin(regwrin),
    .memtoregin(memtoregin), .branaddrin(branaddrin), .jmpaddrin(jmpaddrin), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .pcsrc(pcsrc), .pcaddr(pcaddr), .rdataout(rdataout), .aluoutout(aluoutout),
    .regdstout(regdstout), .regwrout(regwrout), .memtoregout(memtoregout), .buserr(buserr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One instruction: d = number of WAIT cycles without ack before ack (d > TIMEOUT means never)
  task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic rw, input logic [6:0] br, input int d, input logic [31:0] rdat);
    logic acc, al, tk, to, err;
    logic [1:0] epc, mtr;
    logic [4:0] rdst;
    int st;
    acc = rd | wr;
    al = addr[1:0] == 2'b00;
    mtr = 2'($urandom);
    rdst = 5'($urandom);
    {jumpin, bbnein, bbeqin, bblezin, bbgtzin, zeroin, negativein} = br;
    memrdin = rd; memwrin = wr; aluoutin = addr; regdata2in = wd; regwrin = rw;
    regdstmuxin = rdst; memtoregin = mtr;
    branaddrin = $urandom; jmpaddrin = $urandom;
    mem_ack = !acc && $urandom_range(0, 1) == 1;
    mem_rdata = $urandom;
    #1;
    tk = (bbeqin && zeroin) || (bbnein && !zeroin) || (bblezin && (zeroin || negativein))
      || (bbgtzin && !zeroin && !negativein);
    epc = (acc && al) ? 2'd0 : jumpin ? 2'd2 : tk ? 2'd1 : 2'd0;
    check("pcsrc", pcsrc, epc);
    check("pcaddr", pcaddr, epc == 2 ? jmpaddrin : epc == 1 ? branaddrin : 32'd0);
    check("stall_issue", stall, acc && al);
    st = (acc && al) ? 1 : 0;
    to = 0;
    if (acc && al) begin
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        mem_ack = k == d;
        mem_rdata = (k == d) ? rdat : $urandom;
        #1;
        if (k == 0) begin
          check("req", mem_req, 1);
          check("we", mem_we, wr);
          check("addr", mem_addr, addr);
          check("wdata", mem_wdata, wd);
          check("buserr_wait", buserr, 0);
        end
        if (!stall) break;
        st++;
        check("pcsrc_stall", pcsrc, 0);
      end
      to = d > TIMEOUT;
      check("stall_cycles", st, to ? TIMEOUT + 1 : d + 1);
    end
    @(posedge clk); #1;
    mem_ack = 0;
    err = acc && (!al || to);
    if (acc && al && !wr && !to) exp_rdata = rdat;
    check("req_done", mem_req, 0);
    check("buserr", buserr, err);
    check("regwr", regwrout, rw && !err);
    check("rdata", rdataout, exp_rdata);
    check("aluout", aluoutout, addr);
    check("regdst", regdstout, rdst);
    check("memtoreg", memtoregout, mtr);
  endtask

  initial begin
    {memwrin, memrdin, bbnein, bbeqin, bblezin, bbgtzin, jumpin, zeroin, negativein} = '0;
    {aluoutin, regdata2in, branaddrin, jmpaddrin, mem_rdata} = '0;
    regdstmuxin = 0; regwrin = 0; memtoregin = 0; mem_ack = 0;
    #2;
    check("rst_req", mem_req, 0);
    check("rst_buserr", buserr, 0);
    check("rst_aluout", aluoutout, 0);
    check("rst_regwr", regwrout, 0);
    @(posedge clk); #1 rst_n = 1;
    run(1, 0, 32'h100, 32'h0, 1, 7'b0, 3, 32'hDEADBEEF);
    run(0, 1, 32'h0C, 32'h12345678, 0, 7'b0, 0, 32'h0);
    run(1, 0, 32'h102, 32'h0, 1, 7'b0, 0, 32'h0);
    run(1, 0, 32'h40, 32'h0, 1, 7'b0, 99, 32'h0);
    run(0, 0, 32'h8, 32'h0, 1, 7'b0000100, 0, 32'h0);
    run(0, 0, 32'h8, 32'h0, 1, 7'b1000100, 0, 32'h0);
    run(1, 1, 32'h20, 32'h55AA55AA, 1, 7'b0, 1, 32'h11111111);
    run(1, 0, 32'h44, 32'h0, 1, 7'b0, TIMEOUT, 32'hCAFEF00D);
    // Reset while a load is outstanding
    memrdin = 1; memwrin = 0; aluoutin = 32'h200; regwrin = 1; mem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_req", mem_req, 1);
    @(negedge clk);
    rst_n = 0; memrdin = 0; aluoutin = 0; regwrin = 0;
    #1;
    exp_rdata = 0;
    check("midrst_req", mem_req, 0);
    check("midrst_stall", stall, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_rdata", rdataout, 0);
    check("midrst_aluout", aluoutout, 0);
    check("midrst_regwr", regwrout, 0);
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 60; i++) begin
      int r, d;
      logic rd, wr;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      d = r < 8 ? r % 5 : (r == 8 ? TIMEOUT : 99);
      rd = $urandom_range(0, 2) == 0;
      wr = $urandom_range(0, 3) == 0;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run(rd, wr, a, $urandom, 1'($urandom), 7'($urandom), d, $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
